// File: rtl/thor2021_mc_sequencer.sv
// Multi-cycle execution sequencer: runs one MUL/DIV/MEM/FLOW op at a time,
// stalls issue while busy and reports completion with the captured target.
module thor2021_mc_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_TMO = 100
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       issue_i,
  input  logic [2:0] op_i,
  input  logic [5:0] rt_i,
  input  logic       rfwr_i,
  input  logic       flush_i,
  output logic       ready_o,
  output logic       stall_o,
  output logic       mul_start_o,
  output logic       div_start_o,
  input  logic       div_done_i,
  output logic       div_abort_o,
  output logic       mem_req_o,
  input  logic       mem_ack_i,
  output logic       done_o,
  output logic [5:0] done_rt_o,
  output logic       done_rfwr_o,
  output logic       err_o
);

  localparam int CNT_W = 8;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MEM  = 3'd3;
  localparam logic [2:0] OP_FLOW = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_WAIT, S_DIV_WAIT, S_MEM_WAIT, S_FLOW_WAIT, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [5:0]         rt_q;
  logic               rfwr_q, err_q, err_n;
  logic               mul_start_n, div_start_n, div_abort_n, mem_req_n;
  logic               op_ok, accept;

  assign op_ok   = (op_i == OP_MUL) || (op_i == OP_DIV) ||
                   (op_i == OP_MEM) || (op_i == OP_FLOW);
  assign ready_o = ((state == S_IDLE) || (state == S_DONE)) && !flush_i;
  assign stall_o = issue_i & ~ready_o;
  assign accept  = issue_i & ready_o & op_ok;

  assign done_o      = (state == S_DONE);
  assign done_rt_o   = done_o ? rt_q : 6'd0;
  assign done_rfwr_o = done_o & rfwr_q;
  assign err_o       = done_o & err_q;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    err_n       = err_q;
    mul_start_n = 1'b0;
    div_start_n = 1'b0;
    div_abort_n = 1'b0;
    mem_req_n   = 1'b0;
    if (flush_i && state != S_IDLE) begin
      state_n     = S_IDLE;
      cnt_n       = '0;
      div_abort_n = (state == S_DIV_WAIT);
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            err_n = 1'b0;
            unique case (op_i)
              OP_MUL: begin
                state_n     = S_MUL_WAIT;
                mul_start_n = 1'b1;
                cnt_n       = CNT_W'(MUL_LAT - 1);
              end
              OP_DIV: begin
                state_n     = S_DIV_WAIT;
                div_start_n = 1'b1;
                cnt_n       = CNT_W'(DIV_TMO - 1);
              end
              OP_MEM: begin
                state_n   = S_MEM_WAIT;
                mem_req_n = 1'b1;
              end
              default: state_n = S_FLOW_WAIT;
            endcase
          end else if (state == S_DONE) begin
            state_n = S_IDLE;
          end
        end
        // The start cycle does not count toward the latency/timeout window.
        S_MUL_WAIT: begin
          if (!mul_start_o) begin
            if (cnt == '0) state_n = S_DONE;
            else           cnt_n   = cnt - 1'b1;
          end
        end
        S_DIV_WAIT: begin
          if (!div_start_o) begin
            if (div_done_i) begin
              state_n = S_DONE;
              err_n   = 1'b0;
            end else if (cnt == '0) begin
              state_n = S_DONE;
              err_n   = 1'b1;
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_ack_i) state_n   = S_DONE;
          else           mem_req_n = 1'b1;
        end
        S_FLOW_WAIT: state_n = S_DONE;
        default:     state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rt_q        <= '0;
      rfwr_q      <= 1'b0;
      err_q       <= 1'b0;
      mul_start_o <= 1'b0;
      div_start_o <= 1'b0;
      div_abort_o <= 1'b0;
      mem_req_o   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      err_q       <= err_n;
      mul_start_o <= mul_start_n;
      div_start_o <= div_start_n;
      div_abort_o <= div_abort_n;
      mem_req_o   <= mem_req_n;
      if (accept) begin
        rt_q   <= rt_i;
        rfwr_q <= rfwr_i;
      end
    end
  end

endmodule
